// File: rtl/seg_serial_tx.sv
// Serialises a 64-bit seven-segment word MSB first over a divided shift clock.
// seg_pen is raised only once a whole frame is sitting in the external chain.
module seg_serial_tx #(
  parameter int unsigned DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] SEG_TXT,
  output logic        seg_clk,
  output logic        seg_sout,
  output logic        seg_pen,
  output logic        busy,
  output logic        done
);

  localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state;
  logic [63:0]   shreg;
  logic [CW-1:0] divcnt;
  logic [5:0]    bitcnt;
  logic          hi;
  logic          frame_valid;
  logic          load;

  // Requests are honoured only between frames; a DONE cycle can chain a new frame.
  assign load = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      divcnt      <= '0;
      bitcnt      <= '0;
      hi          <= 1'b0;
      frame_valid <= 1'b0;
      seg_clk     <= 1'b0;
      seg_sout    <= 1'b0;
      seg_pen     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state    <= SHIFT;
        shreg    <= SEG_TXT;
        divcnt   <= '0;
        bitcnt   <= '0;
        hi       <= 1'b0;
        seg_clk  <= 1'b0;
        seg_sout <= SEG_TXT[63];
        seg_pen  <= 1'b0;
        busy     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            seg_clk  <= 1'b0;
            seg_sout <= 1'b0;
            busy     <= 1'b0;
            seg_pen  <= frame_valid;
          end
          SHIFT: begin
            if (divcnt == DIV_LAST) begin
              divcnt <= '0;
              if (!hi) begin
                hi      <= 1'b1;
                seg_clk <= 1'b1;
              end else begin
                // End of the high phase: the chain has taken the bit, move on.
                hi       <= 1'b0;
                seg_clk  <= 1'b0;
                shreg    <= {shreg[62:0], 1'b0};
                seg_sout <= shreg[62];
                bitcnt   <= bitcnt + 6'd1;
                if (bitcnt == 6'd63) begin
                  state       <= DONE;
                  seg_sout    <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  seg_pen     <= 1'b1;
                  frame_valid <= 1'b1;
                end
              end
            end else begin
              divcnt <= divcnt + CW'(1);
            end
          end
          DONE: begin
            state    <= IDLE;
            seg_clk  <= 1'b0;
            seg_sout <= 1'b0;
            busy     <= 1'b0;
            seg_pen  <= frame_valid;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_serial_tx.sv
// Bench for seg_serial_tx: cycle-exact output model plus a seg_clk-edge scoreboard,
// exercised on a DIV=2 and a DIV=1 instance.
module tb_seg_serial_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start2 = 1'b0, start1 = 1'b0;
  logic [63:0] txt2 = '0, txt1 = '0;
  logic        sclk2, sout2, pen2, busy2, done2;
  logic        sclk1, sout1, pen1, busy1, done1;

  seg_serial_tx #(.DIV(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .SEG_TXT(txt2),
    .seg_clk(sclk2), .seg_sout(sout2), .seg_pen(pen2), .busy(busy2), .done(done2)
  );
  seg_serial_tx #(.DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .SEG_TXT(txt1),
    .seg_clk(sclk1), .seg_sout(sout1), .seg_pen(pen1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        sel = 1'b0;
  logic        m_sclk, m_sout, m_pen, m_busy, m_done;
  logic        prev_sclk = 1'b0;
  logic        eb;
  logic [63:0] cap = '0;
  int          edges = 0;
  bit          exp_q[$];

  always_comb begin
    m_sclk = sel ? sclk1 : sclk2;
    m_sout = sel ? sout1 : sout2;
    m_pen  = sel ? pen1  : pen2;
    m_busy = sel ? busy1 : busy2;
    m_done = sel ? done1 : done2;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Chain model: every seg_clk rising edge shifts seg_sout in and is scored.
  always @(negedge clk) begin
    if (m_sclk && !prev_sclk) begin
      cap = {cap[62:0], m_sout};
      edges++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_extra_edge actual=edge%0d required=none", edges);
      end else begin
        eb = exp_q.pop_front();
        chk($sformatf("sb_bit%0d", edges), 64'(m_sout), 64'(eb));
      end
    end
    prev_sclk = m_sclk;
  end

  // Expected {seg_clk, seg_sout, busy, done, seg_pen} in frame cycle c.
  function automatic logic [4:0] expv(input logic [63:0] w, input int div, input int c);
    int k;
    logic ph;
    if (c <= 128 * div) begin
      k  = (c - 1) / (2 * div);
      ph = (((c - 1) % (2 * div)) >= div);
      return {ph, w[63-k], 1'b1, 1'b0, 1'b0};
    end
    return 5'b00011;
  endfunction

  task automatic drive(input bit s, input logic st, input logic [63:0] w);
    if (s) begin start1 = st; txt1 = w; end
    else   begin start2 = st; txt2 = w; end
  endtask

  task automatic push_word(input logic [63:0] w);
    for (int i = 63; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  // mode 0: plain, 1: stray starts at cycles 10 and 100, 2: SEG_TXT churns after load
  task automatic frame(input int id, input bit s, input logic [63:0] w, input int mode);
    int div;
    int last;
    div  = s ? 1 : 2;
    last = 128 * div + 1;
    sel  = s;
    @(negedge clk);
    edges = 0;
    cap   = '0;
    push_word(w);
    drive(s, 1'b1, w);
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      chk($sformatf("frm%0d_c%0d", id, c), 64'({m_sclk, m_sout, m_busy, m_done, m_pen}),
          64'(expv(w, div, c)));
      drive(s, (mode == 1) && (c == 10 || c == 100),
            (mode == 2) ? {$urandom(), $urandom()} : w);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("frm%0d_idle%0d", id, c), 64'({m_sclk, m_sout, m_busy, m_done, m_pen}),
          64'(5'b00001));
    end
    chk($sformatf("frm%0d_edges", id), 64'(edges), 64'd64);
    chk($sformatf("frm%0d_capture", id), cap, w);
    chk($sformatf("frm%0d_sb_left", id), 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    bit          s;
    logic [63:0] w;
    int          mode;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [63:0] w1, w2;
    vecs[0] = '{1'b0, 64'h8000_0000_0000_0001, 0};
    vecs[1] = '{1'b1, 64'hA5A5_0F0F_FF00_1234, 0};
    vecs[2] = '{1'b0, 64'h0123_4567_89AB_CDEF, 1};
    vecs[3] = '{1'b1, 64'hDEAD_BEEF_CAFE_F00D, 2};
    vecs[4] = '{1'b0, 64'h0000_0000_0000_0000, 0};
    vecs[5] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0};

    #1 rst_n = 1'b0;
    #2;
    chk("reset_u2", 64'({sclk2, sout2, pen2, busy2, done2}), 64'd0);
    chk("reset_u1", 64'({sclk1, sout1, pen1, busy1, done1}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_pen_u2", 64'(pen2), 64'd0);

    for (int i = 0; i < 6; i++) frame(i, vecs[i].s, vecs[i].w, vecs[i].mode);

    // Back-to-back on DIV=1: start held through the DONE cycle chains a second frame.
    w1 = 64'h0F0F_1E1E_3C3C_7878;
    w2 = 64'h3C3C_A5A5_5A5A_C3C3;
    sel = 1'b1;
    @(negedge clk);
    edges = 0;
    cap   = '0;
    push_word(w1);
    push_word(w2);
    drive(1'b1, 1'b1, w1);
    @(posedge clk);
    for (int c = 1; c <= 258; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_c%0d", c), 64'({m_sclk, m_sout, m_busy, m_done, m_pen}),
          64'((c <= 129) ? expv(w1, 1, c) : expv(w2, 1, c - 129)));
      drive(1'b1, c <= 129, (c >= 3) ? w2 : w1);
    end
    @(negedge clk);
    chk("b2b_after", 64'({m_sclk, m_sout, m_busy, m_done, m_pen}), 64'(5'b00001));
    chk("b2b_edges", 64'(edges), 64'd128);
    chk("b2b_capture", cap, w2);
    chk("b2b_sb_left", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a DIV=2 frame, asserted away from any clock edge.
    sel = 1'b0;
    @(negedge clk);
    edges = 0;
    cap   = '0;
    push_word(64'h5555_5555_5555_5555);
    drive(1'b0, 1'b1, 64'h5555_5555_5555_5555);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 64'h5555_5555_5555_5555);
    for (int i = 0; i < 400 && edges < 20; i++) @(negedge clk);
    chk("rst_wait_edges", 64'(edges), 64'd20);
    chk("rst_pre_busy", 64'(busy2), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_u2", 64'({sclk2, sout2, pen2, busy2, done2}), 64'd0);
    chk("async_rst_u1", 64'({sclk1, sout1, pen1, busy1, done1}), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle%0d", c), 64'({sclk2, sout2, busy2, done2, pen2}), 64'd0);
    end
    frame(10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_serial_tx.md
# seg_serial_tx

Parallel-to-serial transmitter for the 8-digit seven-segment display. It sits downstream of the hex-to-segment encoder and consumes that encoder's 64-bit segment word. On a start request it captures the word and shifts it out MSB first over a divided serial clock into the board's external shift-register chain. It then reports completion and enables the display output.

## Interface
- DIV, 2, seg_clk half-period in clk cycles; legal range 1..255.
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  frame request; sampled on rising clk edges.
- SEG_TXT  input  64  segment word from the encoder; bit 63 is transmitted first.
- seg_clk  output  1  serial shift clock to the external chain; data is taken on its rising edge.
- seg_sout  output  1  serial data.
- seg_pen  output  1  display enable; high only while a complete frame is resident in the chain.
- busy  output  1  a frame is in progress.
- done  output  1  single-cycle pulse at frame completion.

## Operation
- States: IDLE, SHIFT, DONE. All outputs are registered.
- Reset (asynchronous, takes effect immediately): state=IDLE; seg_clk=0; seg_sout=0; seg_pen=0; busy=0; done=0; shift register, divider counter and bit counter all cleared; the frame_valid flag cleared.
- IDLE: seg_clk=0; busy=0; done=0; seg_pen=frame_valid.
  - When start=1, load SEG_TXT into the 64-bit shift register and clear both counters.
  - Next state is SHIFT.
- SHIFT: busy=1; seg_pen=0; seg_sout=shift_reg[63] for the whole bit period.
  - Each bit period is 2*DIV cycles: seg_clk=0 for DIV cycles, then seg_clk=1 for DIV cycles.
  - At the end of the high phase the shift register shifts left by one (zero fill) and the bit counter increments.
  - After the high phase of bit 63 (bit counter wraps 63 to 0), go to DONE.
- DONE (one cycle): seg_clk=0; seg_sout=0; busy=0; done=1; seg_pen=1; frame_valid set.
  - If start=1 in this cycle, reload SEG_TXT and go to SHIFT; otherwise go to IDLE.
- start while busy=1 is ignored. It is not queued.
- SEG_TXT changes after the load cycle have no effect on the frame in progress.
- Divider counter width is ceil(log2(DIV)), with a minimum of 1. Bit counter is 6 bits and wraps naturally.

## Timing
- Cycle 0 is the rising edge that samples start=1 in IDLE. Outputs change at cycle 1.
- seg_sout holds bit 63 during cycles 1..2*DIV. seg_clk rises at cycle DIV+1.
- Bit k (0 = first transmitted, i.e. SEG_TXT[63-k]) is on seg_sout during cycles 1+2*DIV*k .. 2*DIV*(k+1).
- Exactly 64 rising edges of seg_clk per frame. The last one is at cycle 127*DIV+1.
- seg_sout is stable for DIV cycles before and DIV-1 cycles after each seg_clk rising edge.
- done=1 and busy=0 in cycle 128*DIV+1; frame latency is 128*DIV+1 cycles.
- Back-to-back: with start held high, the next frame's first bit appears in cycle 128*DIV+2, and seg_pen is high for exactly that one DONE cycle.
- Reset mid-frame: seg_pen stays 0 until a subsequent frame completes, because the external chain contents are invalid.

## Test plan
- Reset with rst_n=0 asserted mid-cycle -> seg_clk, seg_sout, seg_pen, busy and done all go to 0 immediately, before the next clk edge.
- DIV=2, SEG_TXT=64'h8000_0000_0000_0001, one-cycle start pulse:
  - seg_sout=1 in cycles 1..4, then 0 through cycle 252, then 1 in cycles 253..256.
  - 64 seg_clk rising edges, the first at cycle 3.
  - done=1 and seg_pen=1 at cycle 257; seg_pen stays 1 afterwards.
- DIV=1, SEG_TXT=64'hA5A5_0F0F_FF00_1234:
  - A bench shift-register model clocked on seg_clk captures exactly 64'hA5A5_0F0F_FF00_1234.
  - Frame completes (done=1) at cycle 129.
- start pulses at cycles 10 and 100 during a DIV=2 frame -> both ignored; exactly one done at cycle 257; frame contents unchanged.
- SEG_TXT changed every cycle after load -> serial data equals the value loaded at cycle 0.
- rst_n pulsed low after 20 seg_clk edges, then a fresh start with 64'hFFFF_FFFF_FFFF_FFFF:
  - seg_pen=0 from the reset until that frame's done.
  - The new frame delivers a full 64 edges, all with seg_sout=1.
